ram_access_ctrl: RTL

- Request sequencer that sits directly upstream of the team's small synchronous memory and owns its write/read port.
- Accepts single-beat write or read requests over a valid/ready handshake.
- Drives the memory's address, data, write-enable and read-enable lines with one-cycle strobes.
- Captures read data one cycle after the read strobe and returns it over a valid/ready response handshake. Exactly one operation is in flight at a time.

---
 rtl/ram_access_ctrl_if.sv | 31 +++
 rtl/ram_access_ctrl.sv | 66 ++++++
 2 files changed

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: request/response handshake and memory port bundle
//   req_*  : single-beat write/read request (valid/ready)
//   rsp_*  : read response (valid/ready)
//   ram_*  : synchronous memory port, read data valid the cycle after ram_re
//   slave  : controller view; master : requester/memory view
interface ram_access_ctrl_if #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_we, ram_re
  );
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: one-at-a-time request sequencer owning a synchronous memory port
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : request, response and memory signals
//   wr_cnt, rd_cnt : completed writes / handed-off reads, wrapping
module ram_access_ctrl #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  ram_access_ctrl_if.slave   bus,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   rd_cnt
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_t;
  state_t            state, state_n;
  logic              accept, done, we, re, rsp_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  // ready is a pure decode of the registered state, never of req_valid
  assign bus.req_ready = state == IDLE && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign done          = state == RESP && bus.rsp_ready;
  assign bus.ram_addr  = addr;
  assign bus.ram_wdata = wdata;
  assign bus.ram_we    = we;
  assign bus.ram_re    = re;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? (bus.req_wr ? WRITE : RD_ISSUE) : IDLE;
      WRITE:    state_n = IDLE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT:  state_n = RESP;
      RESP:     state_n = done ? IDLE : RESP;
      default:  state_n = IDLE;
    endcase
  end
  // strobes are high exactly for the WRITE / RD_ISSUE cycle following accept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we        <= 1'b0;
      re        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      rsp_valid <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      we        <= accept && bus.req_wr;
      re        <= accept && !bus.req_wr;
      addr      <= accept ? bus.req_addr : addr;
      wdata     <= accept && bus.req_wr ? bus.req_wdata : wdata;
      rdata     <= state == RD_WAIT ? bus.ram_rdata : rdata;
      rsp_valid <= state == RD_WAIT || (rsp_valid && !done);
      wr_cnt    <= wr_cnt + CNT_W'(state == WRITE);
      rd_cnt    <= rd_cnt + CNT_W'(done);
    end
endmodule
